// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : State, opcode, ALU-op and select encodings for the
//               multi-cycle MIPS control unit. Honours MULTICYCLE_CTRL_JUMP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_R_EXEC    = 4'd6;
  localparam logic [3:0] ST_R_WB      = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_IMM_EXEC  = 4'd9;
  localparam logic [3:0] ST_IMM_WB    = 4'd10;
  localparam logic [3:0] ST_JUMP      = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic       retire;
  } ctrl_t;

  // State entered after DECODE; FETCH doubles as the "illegal opcode" marker.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_R:            decode_target = ST_R_EXEC;
      OP_LW, OP_SW:    decode_target = ST_MEM_ADDR;
      OP_BEQ:          decode_target = ST_BRANCH;
      OP_ADDI, OP_SLTI: decode_target = ST_IMM_EXEC;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      OP_J:            decode_target = ST_JUMP;
`endif
      default:         decode_target = ST_FETCH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Datapath-facing bundle of the multi-cycle control unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
);
  logic [OP_W-1:0]    instr_op_i;
  logic               zero_i;
  logic               mem_ready_i;
  logic               PCWrite_o;
  logic [1:0]         PCSrc_o;
  logic               IorD_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               IRWrite_o;
  logic               RegDst_o;
  logic               RegWrite_o;
  logic               MemtoReg_o;
  logic               ALUSrcA_o;
  logic [1:0]         ALUSrcB_o;
  logic [ALUOP_W-1:0] ALU_op_o;
  logic [3:0]         state_o;
  logic               illegal_o;
  logic               retire_o;
  logic [CNT_W-1:0]   instr_cnt_o;

  modport master (
    output instr_op_i, zero_i, mem_ready_i,
    input  PCWrite_o, PCSrc_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           RegDst_o, RegWrite_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
           state_o, illegal_o, retire_o, instr_cnt_o
  );

  modport slave (
    input  instr_op_i, zero_i, mem_ready_i,
    output PCWrite_o, PCSrc_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           RegDst_o, RegWrite_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
           state_o, illegal_o, retire_o, instr_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_outdec.sv
// ============================================================================
// Module      : multicycle_ctrl_outdec
// Description : Combinational state/opcode to control-vector decode.
//               JUMP state is decoded only with MULTICYCLE_CTRL_JUMP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  logic       i_rst,
  input  logic [3:0] i_state,
  input  logic [5:0] i_op_ir,
  input  logic [5:0] i_op_lat,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  ctrl_t w_c;

  always_comb begin
    w_c = '0;
    case (i_state)
      ST_FETCH: begin
        w_c.mem_read  = 1'b1;
        w_c.alu_src_b = SRCB_FOUR;
        w_c.alu_op    = ALU_ADD;
        w_c.pc_src    = PCSRC_ALU;
        w_c.ir_write  = i_mem_ready;
        w_c.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        w_c.alu_src_b = SRCB_IMM_SH;
        w_c.illegal   = (decode_target(i_op_ir) == ST_FETCH);
      end
      ST_MEM_ADDR: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        w_c.mem_read = 1'b1;
        w_c.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        w_c.mem_to_reg = 1'b1;
        w_c.reg_write  = 1'b1;
        w_c.retire     = 1'b1;
      end
      ST_MEM_WRITE: begin
        w_c.mem_write = 1'b1;
        w_c.iord      = 1'b1;
        w_c.retire    = i_mem_ready;
      end
      ST_R_EXEC: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_RT;
        w_c.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        w_c.reg_dst   = 1'b1;
        w_c.reg_write = 1'b1;
        w_c.retire    = 1'b1;
      end
      ST_BRANCH: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_op    = ALU_SUB;
        w_c.pc_src    = PCSRC_ALUOUT;
        w_c.pc_write  = i_zero;
        w_c.retire    = 1'b1;
      end
      ST_IMM_EXEC: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = (i_op_lat == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      ST_IMM_WB: begin
        w_c.reg_write = 1'b1;
        w_c.retire    = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      ST_JUMP: begin
        w_c.pc_src   = PCSRC_JUMP;
        w_c.pc_write = 1'b1;
        w_c.retire   = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset masks every strobe so an abandoned instruction has no side effects.
    if (i_rst) begin
      w_c.pc_write  = 1'b0;
      w_c.ir_write  = 1'b0;
      w_c.mem_read  = 1'b0;
      w_c.mem_write = 1'b0;
      w_c.reg_write = 1'b0;
      w_c.illegal   = 1'b0;
      w_c.retire    = 1'b0;
    end
  end

  assign o_ctrl = w_c;

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle MIPS main control FSM with retire counter.
//               Optional jump support via MULTICYCLE_CTRL_JUMP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.slave  bus
);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [5:0]       r_op;
  logic [5:0]       w_op;
  logic [CNT_W-1:0] r_cnt;
  ctrl_t            w_ctrl;

  generate
    if (OP_W >= 6) begin : g_op_trunc
      assign w_op = bus.instr_op_i[5:0];
    end else begin : g_op_ext
      assign w_op = {{(6-OP_W){1'b0}}, bus.instr_op_i};
    end
  endgenerate

  multicycle_ctrl_outdec u_outdec (
    .i_rst       (rst_i),
    .i_state     (r_state),
    .i_op_ir     (w_op),
    .i_op_lat    (r_op),
    .i_mem_ready (bus.mem_ready_i),
    .i_zero      (bus.zero_i),
    .o_ctrl      (w_ctrl)
  );

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:     w_next = bus.mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE:    w_next = decode_target(w_op);
      ST_MEM_ADDR:  w_next = (r_op == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  w_next = bus.mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: w_next = bus.mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    w_next = ST_R_WB;
      ST_IMM_EXEC:  w_next = ST_IMM_WB;
      default:      w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FETCH;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_op <= w_op;
      if (w_ctrl.retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.PCWrite_o   = w_ctrl.pc_write;
  assign bus.PCSrc_o     = w_ctrl.pc_src;
  assign bus.IorD_o      = w_ctrl.iord;
  assign bus.MemRead_o   = w_ctrl.mem_read;
  assign bus.MemWrite_o  = w_ctrl.mem_write;
  assign bus.IRWrite_o   = w_ctrl.ir_write;
  assign bus.RegDst_o    = w_ctrl.reg_dst;
  assign bus.RegWrite_o  = w_ctrl.reg_write;
  assign bus.MemtoReg_o  = w_ctrl.mem_to_reg;
  assign bus.ALUSrcA_o   = w_ctrl.alu_src_a;
  assign bus.ALUSrcB_o   = w_ctrl.alu_src_b;
  assign bus.ALU_op_o    = ALUOP_W'(w_ctrl.alu_op);
  assign bus.state_o     = r_state;
  assign bus.illegal_o   = w_ctrl.illegal;
  assign bus.retire_o    = w_ctrl.retire;
  assign bus.instr_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Instruction-level bench for multicycle_ctrl (CNT_W = 4).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(4)) bus ();

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic        zero;
    logic [3:0]  fw;     // not-ready cycles in FETCH
    logic [3:0]  mw;     // not-ready cycles in MEM_READ/MEM_WRITE
    logic [7:0]  cyc;
    logic [31:0] trace;  // state sequence, one nibble per cycle
    logic [3:0]  ret;
    logic [3:0]  ill;
    logic [3:0]  regw;
    logic [3:0]  memw;
    logic [3:0]  pcw;    // PCWrite cycles outside FETCH
    logic [1:0]  pcsrc;  // PCSrc seen on those cycles
    logic [2:0]  alu;    // ALU_op in R_EXEC/IMM_EXEC, 7 if none
  } vec_t;

  vec_t tbl [11];
  vec_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] m_cnt = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    logic [31:0] trace = '0;
    int cyc = 0, ret = 0, ill = 0, regw = 0, memw = 0, pcw = 0, irw = 0;
    logic [1:0] pcsrc = 2'd0;
    logic [2:0] alu = 3'd7;
    int fw = int'(v.fw), mw = int'(v.mw);
    logic [3:0] st;
    bit left = 0, done = 0;
    vec_t e;
    sb.push_back(v);
    for (int k = 0; k < 40; k++) begin
      st = bus.state_o;
      if (left && st == 4'd0) begin done = 1; break; end
      if (st != 4'd0) left = 1;
      // Scramble the IR after DECODE: later states must use the latched opcode.
      bus.instr_op_i = (st <= 4'd1) ? v.op : (v.op ^ 6'h3F);
      bus.zero_i = v.zero;
      if (st == 4'd0) begin
        bus.mem_ready_i = (fw == 0);
        if (fw > 0) fw--;
      end else if (st == 4'd3 || st == 4'd5) begin
        bus.mem_ready_i = (mw == 0);
        if (mw > 0) mw--;
      end else begin
        bus.mem_ready_i = 1'b1;
      end
      #1;
      trace = {trace[27:0], st};
      cyc++;
      ret  += int'(bus.retire_o);
      ill  += int'(bus.illegal_o);
      regw += int'(bus.RegWrite_o);
      memw += int'(bus.MemWrite_o);
      irw  += int'(bus.IRWrite_o);
      if (st != 4'd0 && bus.PCWrite_o) begin pcw++; pcsrc = bus.PCSrc_o; end
      if (st == 4'd6 || st == 4'd9) alu = bus.ALU_op_o;
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d.done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d.cycles", idx), 32'(cyc), 32'(e.cyc));
    chk($sformatf("v%0d.trace", idx), trace, e.trace);
    chk($sformatf("v%0d.retire", idx), 32'(ret), 32'(e.ret));
    chk($sformatf("v%0d.illegal", idx), 32'(ill), 32'(e.ill));
    chk($sformatf("v%0d.regwrite", idx), 32'(regw), 32'(e.regw));
    chk($sformatf("v%0d.memwrite", idx), 32'(memw), 32'(e.memw));
    chk($sformatf("v%0d.irwrite", idx), 32'(irw), 32'd1);
    chk($sformatf("v%0d.pcwrite", idx), 32'(pcw), 32'(e.pcw));
    chk($sformatf("v%0d.pcsrc", idx), 32'(pcsrc), 32'(e.pcsrc));
    chk($sformatf("v%0d.aluop", idx), 32'(alu), 32'(e.alu));
    m_cnt = m_cnt + e.ret;
    chk($sformatf("v%0d.count", idx), 32'(bus.instr_cnt_o), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 4'd0;
  endtask

  initial begin
    //            op     z     fw    mw    cyc    trace         ret   ill   regw  memw  pcw   pcsrc alu
    tbl[0]  = '{6'h23, 1'b0, 4'd0, 4'd0, 8'd5, 32'h0001234, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 3'd7};
    tbl[1]  = '{6'h2B, 1'b0, 4'd0, 4'd3, 8'd7, 32'h0125555, 4'd1, 4'd0, 4'd0, 4'd4, 4'd0, 2'd0, 3'd7};
    tbl[2]  = '{6'h00, 1'b0, 4'd0, 4'd0, 8'd4, 32'h0000167, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 3'd2};
    tbl[3]  = '{6'h04, 1'b1, 4'd0, 4'd0, 8'd3, 32'h0000018, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 2'd1, 3'd7};
    tbl[4]  = '{6'h04, 1'b0, 4'd0, 4'd0, 8'd3, 32'h0000018, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 3'd7};
    tbl[5]  = '{6'h3F, 1'b0, 4'd0, 4'd0, 8'd2, 32'h0000001, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 3'd7};
`ifdef MULTICYCLE_CTRL_JUMP_EN
    tbl[6]  = '{6'h02, 1'b0, 4'd0, 4'd0, 8'd3, 32'h000001B, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 2'd2, 3'd7};
`else
    tbl[6]  = '{6'h02, 1'b0, 4'd0, 4'd0, 8'd2, 32'h0000001, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 3'd7};
`endif
    tbl[7]  = '{6'h0A, 1'b0, 4'd0, 4'd0, 8'd4, 32'h000019A, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 3'd3};
    tbl[8]  = '{6'h08, 1'b0, 4'd0, 4'd0, 8'd4, 32'h000019A, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 3'd0};
    tbl[9]  = '{6'h23, 1'b0, 4'd2, 4'd0, 8'd7, 32'h0001234, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 3'd7};
    tbl[10] = '{6'h23, 1'b0, 4'd0, 4'd2, 8'd7, 32'h0123334, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 3'd7};

    // Reset: strobes masked even though FETCH with ready would assert them.
    bus.instr_op_i = 6'h23; bus.zero_i = 1'b0; bus.mem_ready_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.state", 32'(bus.state_o), 32'd0);
    chk("rst.count", 32'(bus.instr_cnt_o), 32'd0);
    chk("rst.memread", 32'(bus.MemRead_o), 32'd0);
    chk("rst.irwrite", 32'(bus.IRWrite_o), 32'd0);
    chk("rst.pcwrite", 32'(bus.PCWrite_o), 32'd0);
    rst = 1'b0;
    m_cnt = 4'd0;

    for (int i = 0; i < 11; i++) run(i, tbl[i]);

    // Counter wrap: 17 retires on a 4-bit counter leaves 1.
    do_reset();
    for (int i = 0; i < 17; i++) run(100 + i, tbl[8]);
    chk("wrap.count", 32'(bus.instr_cnt_o), 32'd1);

    // Reset in R_EXEC abandons the instruction.
    bus.instr_op_i = 6'h00; bus.mem_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst.in_rexec", 32'(bus.state_o), 32'd6);
    rst = 1'b1;
    #1;
    chk("midrst.retire", 32'(bus.retire_o), 32'd0);
    @(posedge clk); #1;
    chk("midrst.state", 32'(bus.state_o), 32'd0);
    chk("midrst.count", 32'(bus.instr_cnt_o), 32'd0);
    rst = 1'b0;
    m_cnt = 4'd0;
    #1;
    chk("midrst.regwrite", 32'(bus.RegWrite_o), 32'd0);
    run(200, tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multi-cycle MIPS datapath. It replaces the single-cycle opcode-to-control decode with a state machine that steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It stalls on a memory-ready handshake and traps illegal opcodes. It also counts retired instructions. It sits between the instruction register opcode field and the shared-memory/ALU/register-file/PC datapath.

## Interface
Parameters:
- OP_W, 6, opcode width
- ALUOP_W, 3, ALU_op_o width (≥3)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous and active-high
- instr_op_i  in  OP_W  opcode field of the instruction register
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  shared memory done this cycle
- PCWrite_o  out  1  PC load enable (unconditional or taken branch)
- PCSrc_o  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target
- IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead_o / MemWrite_o  out  1  memory strobes
- IRWrite_o  out  1  instruction register load
- RegDst_o / RegWrite_o / MemtoReg_o  out  1  register-file controls
- ALUSrcA_o  out  1  0 = PC, 1 = rs
- ALUSrcB_o  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- ALU_op_o  out  ALUOP_W  000 add, 001 sub, 010 funct-decoded, 011 slt (zero-extended to width)
- state_o  out  4  current state, for debug
- illegal_o  out  1  one-cycle pulse on unsupported opcode
- retire_o  out  1  one-cycle pulse on the last cycle of each completed instruction
- instr_cnt_o  out  CNT_W  retired-instruction count

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, IMM_EXEC 9, IMM_WB 10, JUMP 11. Codes 12–15 are unreachable and return to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU_op=add, PCSrc=0. IRWrite and PCWrite are asserted only when mem_ready_i=1. The state holds in FETCH until mem_ready_i=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALU_op=add (branch target into ALUOut). Next state by opcode:
  - R 0x00 → R_EXEC
  - lw 0x23 / sw 0x2B → MEM_ADDR
  - beq 0x04 → BRANCH
  - addi 0x08 / slti 0x0A → IMM_EXEC
  - any other opcode → illegal_o=1, then FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, add. Next is MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: MemRead=1, IorD=1. Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready_i; on that cycle retire_o=1 and the next state is FETCH.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, retire_o=1.
- R_EXEC: ALUSrcA=1, ALUSrcB=0, ALU_op=010.
- R_WB: RegDst=1, RegWrite=1, retire_o=1.
- BRANCH: ALUSrcA=1, ALUSrcB=0, sub, PCSrc=1, PCWrite=zero_i, retire_o=1.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=2, ALU_op = add (addi) or slt (slti). The opcode is latched in DECODE into an internal register, so IR changes do not affect later states.
- IMM_WB: RegDst=0, RegWrite=1, retire_o=1.
- Every signal not listed for a state is 0 in that state.
- instr_cnt_o increments on each retire_o and wraps modulo 2^CNT_W. Illegal opcodes do not retire.

## Timing
- Outputs are combinational from the state register, plus the mem_ready_i/zero_i gating stated above. They are not registered.
- Cycle counts with mem_ready_i held at 1:
  - lw 5
  - sw, R-type, addi, slti 4
  - beq 3
  - j 3
  - illegal 2
- Each wait cycle adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Reset:
  - While rst_i=1, all strobes are forced to 0 combinationally: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal_o, retire_o.
  - On the reset edge: state=FETCH, instr_cnt_o=0, latched opcode=0.
  - Reset asserted mid-instruction abandons it with no retire.
- If mem_ready_i is asserted outside FETCH/MEM_READ/MEM_WRITE, it is ignored.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN defined:
  - Opcode 0x02 goes DECODE→JUMP.
  - JUMP: PCSrc=2, PCWrite=1, retire_o=1, then FETCH.
- MULTICYCLE_CTRL_JUMP_EN undefined:
  - Opcode 0x02 is illegal.
  - State 11 is unreachable.

## Structure
- Package multicycle_ctrl_pkg holds:
  - the state encoding constants
  - opcode constants (R, LW, SW, BEQ, ADDI, SLTI, J)
  - ALU_op encodings
  - ALUSrcB/PCSrc select encodings
- One sub-module, multicycle_ctrl_outdec: a purely combinational state-plus-opcode to control-vector decode. The top level keeps the state register, opcode latch and counter.

## Test plan
- Reset, then lw with mem_ready_i=1 → states 0,1,2,3,4. RegWrite=1 and MemtoReg=1 in cycle 5 only. instr_cnt_o=1.
- sw with mem_ready_i low for 3 cycles in MEM_WRITE → MemWrite held for 4 cycles. retire_o pulses once on the ready cycle. Total 7 cycles.
- beq with zero_i=1, then beq with zero_i=0 → PCWrite=1 with PCSrc=1 in BRANCH for the first only. Each takes 3 cycles.
- Opcode 0x3F → illegal_o pulse in DECODE, back to FETCH, instr_cnt_o unchanged. With the macro undefined, opcode 0x02 behaves the same.
- With CNT_W=4, retire 17 instructions → instr_cnt_o=1 (wrap). Assert rst_i in R_EXEC → next state FETCH, count 0, no RegWrite.
- slti then addi → ALU_op=011 then 000 in IMM_EXEC. IR changed during IMM_EXEC has no effect.
